// File: rtl/ili9225_spi_receiver_pkg.sv
// Shared ILI9225 constants and receiver FSM state type.
// Also pulled in by the matching controller.
package ili9225_pkg;

  localparam int H_RES_DEF = 176;
  localparam int V_RES_DEF = 220;

  localparam logic [7:0] REG_GRAM_X = 8'h20;
  localparam logic [7:0] REG_GRAM_Y = 8'h21;
  localparam logic [7:0] REG_GRAM   = 8'h22;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INDEX,
    ST_DATA_HI,
    ST_DATA_LO
  } state_t;

endpackage

// File: rtl/ili9225_spi_receiver_if.sv
// 4-wire ILI9225 link: chip select, serial clock, data and data/command.
// The controller drives it; the receiver observes it.
interface ili9225_spi_if;

  logic spi_cs;
  logic spi_sck;
  logic spi_mosi;
  logic spi_dc;

  modport master (
    output spi_cs, spi_sck, spi_mosi, spi_dc
  );

  modport slave (
    input spi_cs, spi_sck, spi_mosi, spi_dc
  );

endinterface

// File: rtl/ili9225_spi_receiver_deser.sv
// Oversampling SPI mode-0 byte deserializer.
// Flags completed bytes, chip-select release and unfinished bytes.
module spi_slave_deser (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_cs,
  input  logic       i_sck,
  input  logic       i_mosi,
  input  logic       i_dc,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_dc,
  output logic       o_cs_rise,
  output logic       o_partial
);

  logic       r_cs_m, r_cs_s, r_cs_d;
  logic       r_sck_m, r_sck_s, r_sck_d;
  logic       r_mosi_m, r_mosi_s;
  logic       r_dc_m, r_dc_s;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_shift;
  logic       w_rise;

  assign w_rise = r_sck_s & ~r_sck_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cs_m    <= 1'b0;
      r_cs_s    <= 1'b0;
      r_cs_d    <= 1'b0;
      r_sck_m   <= 1'b0;
      r_sck_s   <= 1'b0;
      r_sck_d   <= 1'b0;
      r_mosi_m  <= 1'b0;
      r_mosi_s  <= 1'b0;
      r_dc_m    <= 1'b0;
      r_dc_s    <= 1'b0;
      r_bit_cnt <= 3'd0;
      r_shift   <= 7'd0;
    end else begin
      r_cs_m   <= i_cs;
      r_cs_s   <= r_cs_m;
      r_cs_d   <= r_cs_s;
      r_sck_m  <= i_sck;
      r_sck_s  <= r_sck_m;
      r_sck_d  <= r_sck_s;
      r_mosi_m <= i_mosi;
      r_mosi_s <= r_mosi_m;
      r_dc_m   <= i_dc;
      r_dc_s   <= r_dc_m;
      if (r_cs_s) begin
        r_bit_cnt <= 3'd0;
      end else if (w_rise) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_shift   <= {r_shift[5:0], r_mosi_s};
      end
    end
  end

  // The 8th bit is taken straight from the synchronizer
  assign o_byte_valid = w_rise & ~r_cs_s & (r_bit_cnt == 3'd7);
  assign o_byte       = {r_shift, r_mosi_s};
  assign o_dc         = r_dc_s;
  assign o_cs_rise    = r_cs_s & ~r_cs_d;
  assign o_partial    = (r_bit_cnt != 3'd0);

endmodule

// File: rtl/ili9225_spi_receiver.sv
// ILI9225 link decoder: index/register/GRAM pixel reconstruction
// with GRAM address tracking, frame checksum and sticky error flag.
module ili9225_spi_receiver
  import ili9225_pkg::*;
#(
  parameter int         H_RES      = H_RES_DEF,
  parameter int         V_RES      = V_RES_DEF,
  parameter int         RESOLUTION = H_RES_DEF * V_RES_DEF,
  parameter logic [7:0] GRAM_REG   = REG_GRAM
) (
  input  logic         clk,
  input  logic         rst,
  ili9225_spi_if.slave spi,
  output logic         idx_valid,
  output logic [7:0]   idx_byte,
  output logic         reg_valid,
  output logic [7:0]   reg_addr,
  output logic [15:0]  reg_data,
  output logic         pix_valid,
  output logic [15:0]  pix_data,
  output logic [7:0]   pix_x,
  output logic [7:0]   pix_y,
  output logic         frame_done,
  output logic [15:0]  frame_sum,
  output logic         proto_err
);

  logic        w_bv, w_dc, w_cs_rise, w_partial;
  logic [7:0]  w_byte;
  logic [15:0] w_word;
  logic        w_idx_ev, w_hi_ev, w_word_ev, w_err_ev;
  state_t      r_state, w_state_nxt;
  logic        r_idx_seen;
  logic [7:0]  r_hi, r_ac_x, r_ac_y, r_x, r_y;
  logic [15:0] r_pix_cnt;

  spi_slave_deser u_deser (
    .clk          (clk),
    .rst          (rst),
    .i_cs         (spi.spi_cs),
    .i_sck        (spi.spi_sck),
    .i_mosi       (spi.spi_mosi),
    .i_dc         (spi.spi_dc),
    .o_byte_valid (w_bv),
    .o_byte       (w_byte),
    .o_dc         (w_dc),
    .o_cs_rise    (w_cs_rise),
    .o_partial    (w_partial)
  );

  assign w_word = {r_hi, w_byte};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_ev    = 1'b0;
    w_hi_ev     = 1'b0;
    w_word_ev   = 1'b0;
    w_err_ev    = 1'b0;
    if (w_cs_rise) begin
      w_state_nxt = ST_IDLE;
      w_err_ev    = w_partial | (r_state == ST_DATA_LO);
    end else if (w_bv) begin
      if (!w_dc) begin
        w_idx_ev    = 1'b1;
        w_state_nxt = ST_DATA_HI;
      end else if (!r_idx_seen) begin
        w_err_ev    = 1'b1;
      end else if (r_state == ST_DATA_LO) begin
        w_word_ev   = 1'b1;
        w_state_nxt = ST_DATA_HI;
      end else begin
        w_hi_ev     = 1'b1;
        w_state_nxt = ST_DATA_LO;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_valid  <= 1'b0;
      idx_byte   <= 8'd0;
      reg_valid  <= 1'b0;
      reg_addr   <= 8'd0;
      reg_data   <= 16'd0;
      pix_valid  <= 1'b0;
      pix_data   <= 16'd0;
      pix_x      <= 8'd0;
      pix_y      <= 8'd0;
      frame_done <= 1'b0;
      frame_sum  <= 16'd0;
      proto_err  <= 1'b0;
      r_idx_seen <= 1'b0;
      r_hi       <= 8'd0;
      r_ac_x     <= 8'd0;
      r_ac_y     <= 8'd0;
      r_x        <= 8'd0;
      r_y        <= 8'd0;
      r_pix_cnt  <= 16'd0;
    end else begin
      idx_valid  <= 1'b0;
      reg_valid  <= 1'b0;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (w_err_ev) proto_err <= 1'b1;
      if (w_hi_ev)  r_hi <= w_byte;
      if (w_idx_ev) begin
        idx_valid  <= 1'b1;
        idx_byte   <= w_byte;
        r_idx_seen <= 1'b1;
        if (w_byte == GRAM_REG) begin
          r_pix_cnt <= 16'd0;
          frame_sum <= 16'd0;
          r_x       <= r_ac_x;
          r_y       <= r_ac_y;
        end
      end
      if (w_word_ev && idx_byte == GRAM_REG) begin
        pix_valid <= 1'b1;
        pix_data  <= w_word;
        pix_x     <= r_x;
        pix_y     <= r_y;
        frame_sum <= frame_sum + w_word;
        if (r_x == 8'(H_RES - 1)) begin
          r_x <= 8'd0;
          r_y <= (r_y == 8'(V_RES - 1)) ? 8'd0 : r_y + 8'd1;
        end else begin
          r_x <= r_x + 8'd1;
        end
        // Saturate so frame_done fires once per GRAM write
        if (r_pix_cnt != 16'(RESOLUTION)) begin
          r_pix_cnt  <= r_pix_cnt + 16'd1;
          frame_done <= (r_pix_cnt == 16'(RESOLUTION - 1));
        end
      end else if (w_word_ev) begin
        reg_valid <= 1'b1;
        reg_addr  <= idx_byte;
        reg_data  <= w_word;
        if (idx_byte == REG_GRAM_X) r_ac_x <= w_byte;
        if (idx_byte == REG_GRAM_Y) r_ac_y <= w_byte;
      end
    end
  end

endmodule
